// File: rtl/mux_pkt_arbiter_if.sv
// Handshake bundle between the two mux inputs, the downstream port and the packet arbiter.
// The master side drives flit valid/type/VC and ordy; the slave (arbiter) returns select and status.
interface mux_pkt_arbiter_if #(
    parameter int unsigned TYPEW = 2,
    parameter int unsigned VCHW  = 1,
    parameter int unsigned CNTW  = 7
);
    logic             ivalid_0;
    logic [TYPEW-1:0] itype_0;
    logic [VCHW-1:0]  ivch_0;
    logic             ivalid_1;
    logic [TYPEW-1:0] itype_1;
    logic [VCHW-1:0]  ivch_1;
    logic             ordy;

    logic [1:0]       sel;
    logic             grant_0;
    logic             grant_1;
    logic [VCHW-1:0]  ovch;
    logic             busy;
    logic             err;
    logic [CNTW-1:0]  flit_cnt;

    modport master (
        output ivalid_0, itype_0, ivch_0,
        output ivalid_1, itype_1, ivch_1,
        output ordy,
        input  sel, grant_0, grant_1, ovch, busy, err, flit_cnt
    );

    modport slave (
        input  ivalid_0, itype_0, ivch_0,
        input  ivalid_1, itype_1, ivch_1,
        input  ordy,
        output sel, grant_0, grant_1, ovch, busy, err, flit_cnt
    );
endinterface

// File: rtl/mux_pkt_arbiter.sv
// Wormhole packet arbiter for a 2:1 router output mux: locks the select from HEAD to TAIL,
// alternates priority between packets and breaks stalled locks with an idle watchdog.
module mux_pkt_arbiter #(
    parameter int unsigned TYPEW = 2,
    parameter int unsigned VCHW  = 1,
    parameter int unsigned TOUT  = 64,
    parameter int unsigned CNTW  = 7
) (
    input logic              clk,
    input logic              rst_,
    mux_pkt_arbiter_if.slave bus
);

    localparam logic [TYPEW-1:0] TypeHead = TYPEW'(2'b01);
    localparam logic [TYPEW-1:0] TypeTail = TYPEW'(2'b11);
    localparam logic [CNTW-1:0]  CntMax   = {CNTW{1'b1}};
    localparam logic [CNTW-1:0]  ToutCnt  = CNTW'(TOUT);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLock0 = 2'd1,
        StLock1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [VCHW-1:0] ovch_q, ovch_d;
    logic [CNTW-1:0] flit_cnt_q, flit_cnt_d;
    logic [CNTW-1:0] wdog_q, wdog_d;
    logic            ptr_q, ptr_d;

    logic             req_0, req_1;
    logic             lock_in1;
    logic             cur_valid;
    logic [TYPEW-1:0] cur_type;
    logic             cur_grant;
    logic [CNTW-1:0]  wdog_inc;
    logic             grant_0, grant_1;
    logic             err_c;

    assign req_0 = bus.ivalid_0 && (bus.itype_0 == TypeHead);
    assign req_1 = bus.ivalid_1 && (bus.itype_1 == TypeHead);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ovch_d     = ovch_q;
        flit_cnt_d = flit_cnt_q;
        wdog_d     = wdog_q;
        ptr_d      = ptr_q;
        lock_in1   = 1'b0;
        cur_valid  = 1'b0;
        cur_type   = '0;
        cur_grant  = 1'b0;
        wdog_inc   = wdog_q + CNTW'(1);
        grant_0    = 1'b0;
        grant_1    = 1'b0;
        err_c      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Input 0 wins when alone or when both request and the pointer favours it.
                if (req_0 && (!req_1 || !ptr_q)) begin
                    state_d    = StLock0;
                    sel_d      = 2'b01;
                    ovch_d     = bus.ivch_0;
                    flit_cnt_d = '0;
                    wdog_d     = '0;
                end else if (req_1) begin
                    state_d    = StLock1;
                    sel_d      = 2'b10;
                    ovch_d     = bus.ivch_1;
                    flit_cnt_d = '0;
                    wdog_d     = '0;
                end
            end

            StLock0, StLock1: begin
                lock_in1  = (state_q == StLock1);
                cur_valid = lock_in1 ? bus.ivalid_1 : bus.ivalid_0;
                cur_type  = lock_in1 ? bus.itype_1 : bus.itype_0;
                cur_grant = cur_valid && bus.ordy;
                grant_0   = cur_grant && !lock_in1;
                grant_1   = cur_grant && lock_in1;

                if (cur_grant) begin
                    wdog_d = '0;
                    if (flit_cnt_q != CntMax) begin
                        flit_cnt_d = flit_cnt_q + CNTW'(1);
                    end
                    if (cur_type == TypeTail) begin
                        state_d = StIdle;
                        sel_d   = 2'b00;
                        ptr_d   = !lock_in1;
                    end else if ((cur_type == TypeHead) && (flit_cnt_q != '0)) begin
                        // Stray HEAD inside a packet: flag it but keep the lock.
                        err_c = 1'b1;
                    end
                end else if (!cur_valid) begin
                    // Only a silent sender ages the watchdog; back-pressure does not.
                    if (wdog_inc == ToutCnt) begin
                        err_c   = 1'b1;
                        state_d = StIdle;
                        sel_d   = 2'b00;
                        wdog_d  = '0;
                        ptr_d   = !lock_in1;
                    end else begin
                        wdog_d = wdog_inc;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                sel_d   = 2'b00;
            end
        endcase

        if (!rst_) begin
            grant_0 = 1'b0;
            grant_1 = 1'b0;
            err_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q    <= StIdle;
            sel_q      <= 2'b00;
            ovch_q     <= '0;
            flit_cnt_q <= '0;
            wdog_q     <= '0;
            ptr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ovch_q     <= ovch_d;
            flit_cnt_q <= flit_cnt_d;
            wdog_q     <= wdog_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.grant_0  = grant_0;
    assign bus.grant_1  = grant_1;
    assign bus.ovch     = ovch_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.err      = err_c;
    assign bus.flit_cnt = flit_cnt_q;

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// Directed bench for mux_pkt_arbiter: inputs change on the falling edge, outputs are
// sampled 1 time unit later, so combinational grants/err are seen before the next rising edge.
module tb_mux_pkt_arbiter;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] DATA = 2'b10;
    localparam logic [1:0] TAIL = 2'b11;

    logic clk = 1'b0;
    logic rst_;
    int   n_chk = 0;
    int   n_bad = 0;

    mux_pkt_arbiter_if #(.TYPEW(2), .VCHW(1), .CNTW(7)) bus ();

    mux_pkt_arbiter #(
        .TYPEW(2),
        .VCHW (1),
        .TOUT (64),
        .CNTW (7)
    ) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [1:0] t0, input logic v1,
                         input logic [1:0] t1, input logic rdy);
        @(negedge clk);
        bus.ivalid_0 = v0;
        bus.itype_0  = t0;
        bus.ivalid_1 = v1;
        bus.itype_1  = t1;
        bus.ordy     = rdy;
        #1;
    endtask

    function automatic logic [1:0] pkt_type(input int i, input int n);
        if (i == 0) return HEAD;
        if (i == n - 1) return TAIL;
        return DATA;
    endfunction

    initial begin
        int   g0;
        int   g1;
        int   sel_ok;
        logic err_seen;

        rst_         = 1'b0;
        bus.ivalid_0 = 1'b0;
        bus.itype_0  = NONE;
        bus.ivch_0   = 1'b0;
        bus.ivalid_1 = 1'b0;
        bus.itype_1  = NONE;
        bus.ivch_1   = 1'b1;
        bus.ordy     = 1'b1;

        // Reset state, with junk on the inputs
        drive(1'b1, TAIL, 1'b1, HEAD, 1'b1);
        check_eq("rst_sel", bus.sel, 2'b00);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_cnt", bus.flit_cnt, 0);
        check_eq("rst_ovch", bus.ovch, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_grants", {bus.grant_0, bus.grant_1}, 2'b00);
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        // Input 1 alone: HEAD, 20 DATA, TAIL
        drive(1'b0, NONE, 1'b1, HEAD, 1'b1);
        check_eq("solo_idle_grant", bus.grant_1, 0);
        check_eq("solo_idle_sel", bus.sel, 2'b00);
        g1 = 0; sel_ok = 0; err_seen = 1'b0;
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, NONE, 1'b1, pkt_type(i, 22), 1'b1);
            g1 += int'(bus.grant_1);
            if (bus.sel == 2'b10) sel_ok++;
            err_seen |= bus.err;
        end
        check_eq("solo_grants", g1, 22);
        check_eq("solo_sel_held", sel_ok, 22);
        drive(1'b0, NONE, 1'b0, NONE, 1'b1);
        err_seen |= bus.err;
        check_eq("solo_sel_release", bus.sel, 2'b00);
        check_eq("solo_busy", bus.busy, 0);
        check_eq("solo_cnt", bus.flit_cnt, 22);
        check_eq("solo_ovch", bus.ovch, 1);
        check_eq("solo_err", err_seen, 0);

        // Simultaneous HEADs, pointer at input 0
        drive(1'b1, HEAD, 1'b1, HEAD, 1'b1);
        check_eq("dual_idle_grants", {bus.grant_0, bus.grant_1}, 2'b00);
        g0 = 0; g1 = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pkt_type(i, 4), 1'b1, HEAD, 1'b1);
            if (i == 0) check_eq("dual_first_sel", bus.sel, 2'b01);
            if (i == 0) check_eq("dual_first_ovch", bus.ovch, 0);
            g0 += int'(bus.grant_0);
            g1 += int'(bus.grant_1);
        end
        check_eq("dual_g0", g0, 4);
        check_eq("dual_g1_blocked", g1, 0);
        drive(1'b0, NONE, 1'b1, HEAD, 1'b1);
        check_eq("dual_bubble_sel", bus.sel, 2'b00);
        check_eq("dual_bubble_grant", bus.grant_1, 0);
        g1 = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, NONE, 1'b1, pkt_type(i, 4), 1'b1);
            if (i == 0) check_eq("dual_second_sel", bus.sel, 2'b10);
            if (i == 0) check_eq("dual_second_ovch", bus.ovch, 1);
            g1 += int'(bus.grant_1);
        end
        check_eq("dual_g1", g1, 4);
        drive(1'b0, NONE, 1'b0, NONE, 1'b1);
        check_eq("dual_end_sel", bus.sel, 2'b00);
        check_eq("dual_end_cnt", bus.flit_cnt, 4);

        // Back-pressure longer than the watchdog limit must not time out
        drive(1'b1, HEAD, 1'b0, NONE, 1'b1);
        drive(1'b1, HEAD, 1'b0, NONE, 1'b1);
        check_eq("bp_head_grant", bus.grant_0, 1);
        drive(1'b1, DATA, 1'b0, NONE, 1'b1);
        g0 = 0; sel_ok = 0; err_seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            drive(1'b1, DATA, 1'b0, NONE, 1'b0);
            g0 += int'(bus.grant_0);
            if (bus.sel == 2'b01) sel_ok++;
            err_seen |= bus.err;
        end
        check_eq("bp_no_grant", g0, 0);
        check_eq("bp_sel_stable", sel_ok, 70);
        check_eq("bp_no_err", err_seen, 0);
        drive(1'b1, DATA, 1'b0, NONE, 1'b1);
        check_eq("bp_resume", bus.grant_0, 1);
        drive(1'b1, TAIL, 1'b0, NONE, 1'b1);
        check_eq("bp_tail", bus.grant_0, 1);
        drive(1'b0, NONE, 1'b0, NONE, 1'b1);
        check_eq("bp_cnt", bus.flit_cnt, 4);
        check_eq("bp_sel_release", bus.sel, 2'b00);

        // Stalled sender: 3 flits then silence until the watchdog fires
        drive(1'b1, HEAD, 1'b0, NONE, 1'b1);
        drive(1'b1, HEAD, 1'b0, NONE, 1'b1);
        drive(1'b1, DATA, 1'b0, NONE, 1'b1);
        drive(1'b1, DATA, 1'b0, NONE, 1'b1);
        err_seen = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            drive(1'b0, NONE, 1'b0, NONE, 1'b1);
            if (k < 64) err_seen |= bus.err;
            if (k == 64) check_eq("wd_err_pulse", bus.err, 1);
            if (k == 64) check_eq("wd_sel_before", bus.sel, 2'b01);
        end
        check_eq("wd_no_early_err", err_seen, 0);
        drive(1'b1, HEAD, 1'b1, HEAD, 1'b1);
        check_eq("wd_sel_release", bus.sel, 2'b00);
        check_eq("wd_busy", bus.busy, 0);
        check_eq("wd_err_once", bus.err, 0);
        check_eq("wd_cnt", bus.flit_cnt, 3);
        drive(1'b1, HEAD, 1'b1, HEAD, 1'b1);
        check_eq("wd_ptr_sel", bus.sel, 2'b10);
        check_eq("wd_ptr_grants", {bus.grant_0, bus.grant_1}, 2'b01);
        drive(1'b1, HEAD, 1'b1, DATA, 1'b1);
        check_eq("lock1_data", bus.grant_1, 1);

        // Reset in the middle of the input-1 packet
        rst_ = 1'b0;
        drive(1'b1, HEAD, 1'b1, DATA, 1'b1);
        check_eq("mid_rst_grants", {bus.grant_0, bus.grant_1}, 2'b00);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        drive(1'b1, HEAD, 1'b1, HEAD, 1'b1);
        check_eq("mid_rst_sel", bus.sel, 2'b00);
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_cnt", bus.flit_cnt, 0);
        check_eq("mid_rst_idle_grants", {bus.grant_0, bus.grant_1}, 2'b00);

        // Pointer back at 0; then a stray HEAD inside the packet
        drive(1'b1, HEAD, 1'b0, NONE, 1'b1);
        check_eq("mid_rst_ptr_sel", bus.sel, 2'b01);
        check_eq("proto_first_head", {bus.grant_0, bus.err}, 2'b10);
        drive(1'b1, DATA, 1'b0, NONE, 1'b1);
        drive(1'b1, HEAD, 1'b0, NONE, 1'b1);
        check_eq("proto_err", bus.err, 1);
        check_eq("proto_grant", bus.grant_0, 1);
        drive(1'b1, DATA, 1'b0, NONE, 1'b1);
        check_eq("proto_err_clear", bus.err, 0);
        check_eq("proto_lock_held", {bus.sel, bus.busy}, 3'b011);
        drive(1'b1, TAIL, 1'b0, NONE, 1'b1);
        drive(1'b0, NONE, 1'b0, NONE, 1'b1);
        check_eq("proto_cnt", bus.flit_cnt, 5);
        check_eq("proto_release", bus.sel, 2'b00);

        // Non-HEAD flits in IDLE are ignored
        g0 = 0; g1 = 0; err_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, DATA, 1'b1, TAIL, 1'b1);
            g0 += int'(bus.grant_0);
            g1 += int'(bus.grant_1);
            err_seen |= bus.err;
        end
        check_eq("idle_data_grants", g0 + g1, 0);
        check_eq("idle_data_err", err_seen, 0);
        check_eq("idle_data_state", {bus.sel, bus.busy}, 3'b000);
        check_eq("idle_data_cnt", bus.flit_cnt, 5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
